// File: rtl/alu_seq_if.sv
// Bundle of fetch/decode handshake, register-file and ALU signals for alu_seq.
// slave = sequencer side, master = core/environment side.
interface alu_seq_if;
  logic [15:0] insn;
  logic        insn_valid;
  logic        insn_ready;
  logic        done;
  logic        err;
  logic [4:0]  rf_raddr;
  logic [7:0]  rf_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [4:0]  alu_mode;
  logic [7:0]  alu_d;
  logic [7:0]  alu_r;
  logic [7:0]  alu_s;
  logic [15:0] alu_op1w;
  logic [7:0]  alu_R;
  logic [7:0]  alu_S;
  logic [15:0] alu_resw;
  logic [7:0]  sreg;
  logic        sreg_ld;
  logic [7:0]  sreg_din;

  modport slave (
    input  insn, insn_valid, rf_rdata, alu_R, alu_S, alu_resw, sreg_ld, sreg_din,
    output insn_ready, done, err, rf_raddr, rf_we, rf_waddr, rf_wdata,
           alu_mode, alu_d, alu_r, alu_s, alu_op1w, sreg
  );

  modport master (
    output insn, insn_valid, rf_rdata, alu_R, alu_S, alu_resw, sreg_ld, sreg_din,
    input  insn_ready, done, err, rf_raddr, rf_we, rf_waddr, rf_wdata,
           alu_mode, alu_d, alu_r, alu_s, alu_op1w, sreg
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle AVR register-arithmetic sequencer: decode, operand fetch over a
// synchronous-read register file, ALU drive, writeback and SREG ownership.
module alu_seq #(
  parameter logic [7:0] SREG_RST = 8'h00
) (
  input logic  clk,
  input logic  rst_n,
  alu_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FETCH_D, FETCH_R, EXEC, WB_HI, ERR} state_t;
  typedef enum logic [1:0] {C_TWO, C_LDI, C_ONE, C_WIDE} cls_t;

  state_t     r_state, w_next;
  cls_t       r_cls, w_cls;
  logic [4:0] r_mode, w_mode;
  logic [4:0] r_rd, w_rd;
  logic [4:0] r_rr, w_rr;
  logic [7:0] r_k, w_k;
  logic       r_nowb, w_nowb;
  logic       w_sup;
  logic       w_accept;
  logic [7:0] r_sreg;
  logic [7:0] r_d_q;
  logic [7:0] r_hi_q;

  always_comb begin
    w_sup  = 1'b1;
    w_cls  = C_TWO;
    w_mode = 5'd0;
    w_rd   = bus.insn[8:4];
    w_rr   = {bus.insn[9], bus.insn[3:0]};
    w_k    = 8'h00;
    w_nowb = 1'b0;
    if (bus.insn[15:12] == 4'b1110) begin
      w_cls = C_LDI;
      w_rd  = {1'b1, bus.insn[7:4]};
      w_k   = {bus.insn[11:8], bus.insn[3:0]};
    end else if (bus.insn[15:9] == 7'b1001010) begin
      w_cls = C_ONE;
      case (bus.insn[3:0])
        4'h0:    w_mode = 5'd12;
        4'h1:    w_mode = 5'd13;
        4'h2:    w_mode = 5'd14;
        4'h3:    w_mode = 5'd15;
        4'h5:    w_mode = 5'd16;
        4'h6:    w_mode = 5'd17;
        4'h7:    w_mode = 5'd18;
        4'hA:    w_mode = 5'd19;
        default: w_sup  = 1'b0;
      endcase
    end else if (bus.insn[15:9] == 7'b1001011) begin
      // ADIW/SBIW operate on the even register of pairs r24..r31
      w_cls  = C_WIDE;
      w_mode = bus.insn[8] ? 5'd21 : 5'd20;
      w_rd   = {2'b11, bus.insn[5:4], 1'b0};
      w_k    = {2'b00, bus.insn[7:6], bus.insn[3:0]};
    end else begin
      case (bus.insn[15:10])
        6'b000001: begin w_mode = 5'd1; w_nowb = 1'b1; end
        6'b000010: w_mode = 5'd2;
        6'b000011: w_mode = 5'd3;
        6'b000101: begin w_mode = 5'd5; w_nowb = 1'b1; end
        6'b000110: w_mode = 5'd6;
        6'b000111: w_mode = 5'd7;
        6'b001000: w_mode = 5'd8;
        6'b001001: w_mode = 5'd9;
        6'b001010: w_mode = 5'd10;
        6'b001011: w_mode = 5'd0;
        default:   w_sup  = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    bus.insn_ready = 1'b0;
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    bus.rf_raddr   = 5'd0;
    bus.rf_we      = 1'b0;
    bus.rf_waddr   = 5'd0;
    bus.rf_wdata   = 8'h00;
    bus.alu_mode   = 5'd0;
    bus.alu_d      = 8'h00;
    bus.alu_r      = 8'h00;
    bus.alu_s      = r_sreg;
    bus.alu_op1w   = 16'h0000;
    case (r_state)
      IDLE: begin
        bus.insn_ready = 1'b1;
        if (bus.insn_valid) begin
          w_accept = 1'b1;
          if (!w_sup)              w_next = ERR;
          else if (w_cls == C_LDI) w_next = EXEC;
          else                     w_next = FETCH_D;
        end
      end
      FETCH_D: begin
        bus.rf_raddr = r_rd;
        w_next       = FETCH_R;
      end
      FETCH_R: begin
        if (r_cls == C_TWO)       bus.rf_raddr = r_rr;
        else if (r_cls == C_WIDE) bus.rf_raddr = r_rd + 5'd1;
        else                      bus.rf_raddr = r_rd;
        w_next = EXEC;
      end
      EXEC: begin
        bus.alu_mode = r_mode;
        bus.alu_d    = r_d_q;
        bus.alu_r    = (r_cls == C_LDI || r_cls == C_WIDE) ? r_k : bus.rf_rdata;
        bus.alu_op1w = {bus.rf_rdata, r_d_q};
        bus.rf_we    = !r_nowb;
        bus.rf_waddr = r_rd;
        bus.rf_wdata = (r_cls == C_WIDE) ? bus.alu_resw[7:0] : bus.alu_R;
        if (r_cls == C_WIDE) begin
          w_next = WB_HI;
        end else begin
          bus.done = 1'b1;
          w_next   = IDLE;
        end
      end
      WB_HI: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = r_rd + 5'd1;
        bus.rf_wdata = r_hi_q;
        bus.done     = 1'b1;
        w_next       = IDLE;
      end
      ERR: begin
        bus.err = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cls   <= C_TWO;
      r_mode  <= 5'd0;
      r_rd    <= 5'd0;
      r_rr    <= 5'd0;
      r_k     <= 8'h00;
      r_nowb  <= 1'b0;
      r_sreg  <= SREG_RST;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cls  <= w_cls;
        r_mode <= w_mode;
        r_rd   <= w_rd;
        r_rr   <= w_rr;
        r_k    <= w_k;
        r_nowb <= w_nowb;
      end
      // ALU flag update takes priority over the external load
      if (r_state == EXEC)  r_sreg <= bus.alu_S;
      else if (bus.sreg_ld) r_sreg <= bus.sreg_din;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == FETCH_R) r_d_q  <= bus.rf_rdata;
    if (r_state == EXEC)    r_hi_q <= bus.alu_resw[15:8];
  end

  assign bus.sreg = r_sreg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural register file and ALU subset.
// Each step drives one instruction and checks timing, writes and SREG.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if bus();
  alu_seq #(.SREG_RST(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [7:0] rf [32];
  logic       pl_we = 1'b0;
  logic [4:0] pl_addr = 5'd0;
  logic [7:0] pl_dat = 8'h00;

  always @(posedge clk) begin
    if (pl_we) rf[pl_addr] <= pl_dat;
    else if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    bus.rf_rdata <= rf[bus.rf_raddr];
  end

  logic [7:0]  m_res;
  logic [15:0] m_w;
  logic        f_h, f_v, f_n, f_z, f_c;
  always @* begin
    bus.alu_R    = bus.alu_d;
    bus.alu_S    = bus.alu_s;
    bus.alu_resw = bus.alu_op1w;
    m_res = 8'h00; m_w = 16'h0000;
    f_h = 1'b0; f_v = 1'b0; f_n = 1'b0; f_z = 1'b0; f_c = 1'b0;
    case (bus.alu_mode)
      5'd0: bus.alu_R = bus.alu_r;
      5'd3: begin
        m_res = bus.alu_d + bus.alu_r;
        f_h = (bus.alu_d[3] & bus.alu_r[3]) | (bus.alu_r[3] & ~m_res[3]) | (~m_res[3] & bus.alu_d[3]);
        f_v = (bus.alu_d[7] & bus.alu_r[7] & ~m_res[7]) | (~bus.alu_d[7] & ~bus.alu_r[7] & m_res[7]);
        f_c = (bus.alu_d[7] & bus.alu_r[7]) | (bus.alu_r[7] & ~m_res[7]) | (~m_res[7] & bus.alu_d[7]);
        f_n = m_res[7]; f_z = (m_res == 8'h00);
        bus.alu_R = m_res;
        bus.alu_S = {bus.alu_s[7:6], f_h, f_n ^ f_v, f_v, f_n, f_z, f_c};
      end
      5'd5: begin
        m_res = bus.alu_d - bus.alu_r;
        f_h = (~bus.alu_d[3] & bus.alu_r[3]) | (bus.alu_r[3] & m_res[3]) | (m_res[3] & ~bus.alu_d[3]);
        f_v = (bus.alu_d[7] & ~bus.alu_r[7] & ~m_res[7]) | (~bus.alu_d[7] & bus.alu_r[7] & m_res[7]);
        f_c = (~bus.alu_d[7] & bus.alu_r[7]) | (bus.alu_r[7] & m_res[7]) | (m_res[7] & ~bus.alu_d[7]);
        f_n = m_res[7]; f_z = (m_res == 8'h00);
        bus.alu_R = m_res;
        bus.alu_S = {bus.alu_s[7:6], f_h, f_n ^ f_v, f_v, f_n, f_z, f_c};
      end
      5'd20: begin
        m_w = bus.alu_op1w + {8'h00, bus.alu_r};
        f_v = ~bus.alu_op1w[15] & m_w[15];
        f_c = bus.alu_op1w[15] & ~m_w[15];
        f_n = m_w[15]; f_z = (m_w == 16'h0000);
        bus.alu_resw = m_w;
        bus.alu_S = {bus.alu_s[7:5], f_n ^ f_v, f_v, f_n, f_z, f_c};
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_dat = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  int dcyc, ecyc, wecnt;
  logic rdy2;
  logic [4:0] mode_done;
  int wc [4];
  logic [4:0] wa [4];
  logic [7:0] wd [4];

  // Accept at edge T, then sample mid-cycle for 8 cycles; cycle k ends at edge T+k.
  task automatic run(input logic [15:0] ins, input logic ld, input logic [7:0] din);
    @(negedge clk);
    bus.insn = ins; bus.insn_valid = 1'b1; bus.sreg_ld = ld; bus.sreg_din = din;
    @(posedge clk);
    #1 bus.insn_valid = 1'b0; bus.sreg_ld = 1'b0; bus.insn = 16'h0C00;
    dcyc = -1; ecyc = -1; wecnt = 0; rdy2 = 1'b0; mode_done = 5'h1f;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.rf_we && wecnt < 4) begin
        wc[wecnt] = k; wa[wecnt] = bus.rf_waddr; wd[wecnt] = bus.rf_wdata; wecnt++;
      end
      if (bus.done && dcyc < 0) begin dcyc = k; mode_done = bus.alu_mode; end
      if (bus.err && ecyc < 0) ecyc = k;
      if (k == 2) rdy2 = bus.insn_ready;
    end
  endtask

  initial begin
    bus.insn = 16'h0000; bus.insn_valid = 1'b0; bus.sreg_ld = 1'b0; bus.sreg_din = 8'h00;
    #12;
    chk("rst_ready", 16'(bus.insn_ready), 16'd1);
    chk("rst_done_err_we", {13'd0, bus.done, bus.err, bus.rf_we}, 16'd0);
    chk("rst_addrs_mode", {1'b0, bus.rf_raddr, bus.rf_waddr, bus.alu_mode}, 16'd0);
    chk("rst_sreg", 16'(bus.sreg), 16'h00);
    @(negedge clk); rst_n = 1'b1;

    // external SREG load in IDLE
    @(negedge clk); bus.sreg_ld = 1'b1; bus.sreg_din = 8'h81;
    @(negedge clk); bus.sreg_ld = 1'b0;
    chk("sreg_ld_idle", 16'(bus.sreg), 16'h81);

    // LDI r20,0xA5
    run(16'hEA45, 1'b0, 8'h00);
    chk("ldi_done_cyc", 16'(dcyc), 16'd1);
    chk("ldi_we_cnt", 16'(wecnt), 16'd1);
    chk("ldi_waddr", 16'(wa[0]), 16'd20);
    chk("ldi_wdata", 16'(wd[0]), 16'hA5);
    chk("ldi_rf20", 16'(rf[20]), 16'hA5);
    chk("ldi_sreg", 16'(bus.sreg), 16'h81);

    // ADD r1,r2 with SREG cleared by a load coinciding with accept
    preload(5'd1, 8'h7F);
    preload(5'd2, 8'h01);
    run(16'h0C12, 1'b1, 8'h00);
    chk("add_done_cyc", 16'(dcyc), 16'd3);
    chk("add_mode", 16'(mode_done), 16'd3);
    chk("add_we_cyc", 16'(wc[0]), 16'd3);
    chk("add_waddr", 16'(wa[0]), 16'd1);
    chk("add_rf1", 16'(rf[1]), 16'h80);
    chk("add_sreg", 16'(bus.sreg), 16'h2C);

    // CP r16,r17 equal operands
    preload(5'd16, 8'h05);
    preload(5'd17, 8'h05);
    run(16'h1701, 1'b0, 8'h00);
    chk("cp_done_cyc", 16'(dcyc), 16'd3);
    chk("cp_we_cnt", 16'(wecnt), 16'd0);
    chk("cp_sreg", 16'(bus.sreg), 16'h02);

    // unsupported opcode
    run(16'hFFFF, 1'b0, 8'h00);
    chk("err_cyc", 16'(ecyc), 16'd1);
    chk("err_no_done", 16'(dcyc), 16'hFFFF);
    chk("err_we_cnt", 16'(wecnt), 16'd0);
    chk("err_ready_t2", 16'(rdy2), 16'd1);
    chk("err_sreg", 16'(bus.sreg), 16'h02);

    // ADIW r24,1 on 0x00FF
    preload(5'd24, 8'hFF);
    preload(5'd25, 8'h00);
    run(16'h9601, 1'b0, 8'h00);
    chk("adiw_done_cyc", 16'(dcyc), 16'd4);
    chk("adiw_we_cnt", 16'(wecnt), 16'd2);
    chk("adiw_lo_wr", {3'd0, wa[0], wd[0]}, {3'd0, 5'd24, 8'h00});
    chk("adiw_lo_cyc", 16'(wc[0]), 16'd3);
    chk("adiw_hi_wr", {3'd0, wa[1], wd[1]}, {3'd0, 5'd25, 8'h01});
    chk("adiw_hi_cyc", 16'(wc[1]), 16'd4);
    chk("adiw_rf", {rf[25], rf[24]}, 16'h0100);
    chk("adiw_sreg", 16'(bus.sreg), 16'h00);

    // ADIW on 0x7FFF with reset pulsed during WB_HI
    preload(5'd24, 8'hFF);
    preload(5'd25, 8'h7F);
    @(negedge clk);
    bus.insn = 16'h9601; bus.insn_valid = 1'b1;
    @(posedge clk);
    #1 bus.insn_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstwb_we_before", {bus.rf_we, 2'b00, bus.rf_waddr, bus.rf_wdata}, {1'b1, 2'b00, 5'd25, 8'h80});
    chk("rstwb_sreg_before", 16'(bus.sreg), 16'h0C);
    rst_n = 1'b0;
    #1;
    chk("rstwb_we_in_rst", 16'(bus.rf_we), 16'd0);
    chk("rstwb_sreg_in_rst", 16'(bus.sreg), 16'h00);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rstwb_rf25", 16'(rf[25]), 16'h7F);
    chk("rstwb_rf24", 16'(rf[24]), 16'h00);
    chk("rstwb_ready", 16'(bus.insn_ready), 16'd1);
    chk("rstwb_sreg_after", 16'(bus.sreg), 16'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
